// File: rtl/contour_bin_stats.sv
// contour_bin_stats
//
// Scans the contour-bin image in raster order and accumulates per-bin
// statistics for bins 1-7. Label 0 means "no contour" and is ignored. The
// statistics are pixel count, x/y coordinate sums and bounding box.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          level request: scan while high, low aborts and re-arms
//   bram_read      bin BRAM read data (3-bit label)
//   bin_addr_read  bin BRAM read address, y*WIDTH + x
//   busy           high while scanning or draining the read pipeline
//   done           high once the scan completed; statistics stable
//   stat_bin       bin selected for readout (0 reads all zeros)
//   stat_count     pixels labelled stat_bin
//   stat_sum_x     sum of x over those pixels
//   stat_sum_y     sum of y over those pixels
//   stat_min_x/stat_max_x  bounding box x
//   stat_min_y/stat_max_y  bounding box y
//
// Pipeline: the address register plus the BRAM output register give two
// cycles from issuing address n to accumulating its label. A two-stage
// delay line carries {valid, x, y} alongside so the accumulate stage knows
// which pixel the label belongs to.

module contour_bin_stats #(
   parameter int unsigned WIDTH        = 640,
   parameter int unsigned HEIGHT       = 480,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  bram_read,
   output logic [18:0] bin_addr_read,
   output logic        busy,
   output logic        done,
   input  logic [2:0]  stat_bin,
   output logic [18:0] stat_count,
   output logic [27:0] stat_sum_x,
   output logic [27:0] stat_sum_y,
   output logic [9:0]  stat_min_x,
   output logic [9:0]  stat_max_x,
   output logic [8:0]  stat_min_y,
   output logic [8:0]  stat_max_y
);

   localparam logic [18:0] LastAddr  = 19'(WIDTH * HEIGHT - 1);
   localparam logic [9:0]  LastX     = 10'(WIDTH - 1);
   localparam logic [1:0]  DrainLast = 2'(READ_LATENCY);
   localparam logic [9:0]  MinXInit  = 10'd1023;
   localparam logic [8:0]  MinYInit  = 9'd511;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDrain,
      StDone
   } state_e;

   state_e state_q, state_d;

   // Scan position and issued address
   logic [9:0]  x_q;
   logic [8:0]  y_q;
   logic [18:0] pos_q;
   logic [18:0] addr_q;
   logic [1:0]  drain_q;

   // Delay line matching the BRAM read path
   logic        s1_valid_q, s2_valid_q;
   logic [9:0]  s1_x_q, s2_x_q;
   logic [8:0]  s1_y_q, s2_y_q;

   // Per-bin statistics, entry b holds bin b+1
   logic [18:0] cnt_q   [7];
   logic [27:0] sum_x_q [7];
   logic [27:0] sum_y_q [7];
   logic [9:0]  min_x_q [7];
   logic [9:0]  max_x_q [7];
   logic [8:0]  min_y_q [7];
   logic [8:0]  max_y_q [7];

   logic       clear;
   logic       issue;
   logic       last_issue;
   logic       acc_en;
   logic [2:0] acc_idx;
   logic [2:0] rd_idx;

   assign clear      = (state_q == StIdle) && start;
   assign issue      = (state_q == StScan) && start;
   assign last_issue = issue && (pos_q == LastAddr);

   // Dropping start mid-scan discards whatever is still in the delay line.
   assign acc_en  = s2_valid_q && start && (bram_read != 3'd0) &&
                    ((state_q == StScan) || (state_q == StDrain));
   assign acc_idx = bram_read - 3'd1;

   //------------------------------------------------------------------
   // FSM next state
   //------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StScan;
         end
         StScan: begin
            if (!start)          state_d = StIdle;
            else if (last_issue) state_d = StDrain;
         end
         StDrain: begin
            if (!start)                    state_d = StIdle;
            else if (drain_q == DrainLast) state_d = StDone;
         end
         StDone: begin
            if (!start) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   //------------------------------------------------------------------
   // FSM state, scan counters and delay line
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         x_q        <= '0;
         y_q        <= '0;
         pos_q      <= '0;
         addr_q     <= '0;
         drain_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_x_q     <= '0;
         s2_y_q     <= '0;
      end else begin
         state_q <= state_d;

         s1_valid_q <= issue;
         s2_valid_q <= s1_valid_q;
         s2_x_q     <= s1_x_q;
         s2_y_q     <= s1_y_q;

         if (issue) begin
            addr_q <= pos_q;
            s1_x_q <= x_q;
            s1_y_q <= y_q;
            pos_q  <= pos_q + 19'd1;
            if (x_q == LastX) begin
               x_q <= '0;
               y_q <= y_q + 9'd1;
            end else begin
               x_q <= x_q + 10'd1;
            end
         end

         if (clear) begin
            x_q    <= '0;
            y_q    <= '0;
            pos_q  <= '0;
            addr_q <= '0;
         end

         // DRAIN runs one cycle past READ_LATENCY so the last label has
         // landed in the statistics before done is raised.
         if (state_q == StDrain) drain_q <= drain_q + 2'd1;
         else                    drain_q <= '0;
      end
   end

   //------------------------------------------------------------------
   // Statistics registers
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 7; b++) begin
            cnt_q[b]   <= '0;
            sum_x_q[b] <= '0;
            sum_y_q[b] <= '0;
            min_x_q[b] <= MinXInit;
            max_x_q[b] <= '0;
            min_y_q[b] <= MinYInit;
            max_y_q[b] <= '0;
         end
      end else if (clear) begin
         for (int b = 0; b < 7; b++) begin
            cnt_q[b]   <= '0;
            sum_x_q[b] <= '0;
            sum_y_q[b] <= '0;
            min_x_q[b] <= MinXInit;
            max_x_q[b] <= '0;
            min_y_q[b] <= MinYInit;
            max_y_q[b] <= '0;
         end
      end else if (acc_en) begin
         // One pixel per cycle, so only one set is ever written.
         cnt_q[acc_idx]   <= cnt_q[acc_idx] + 19'd1;
         sum_x_q[acc_idx] <= sum_x_q[acc_idx] + 28'(s2_x_q);
         sum_y_q[acc_idx] <= sum_y_q[acc_idx] + 28'(s2_y_q);
         if (s2_x_q < min_x_q[acc_idx]) min_x_q[acc_idx] <= s2_x_q;
         if (s2_x_q > max_x_q[acc_idx]) max_x_q[acc_idx] <= s2_x_q;
         if (s2_y_q < min_y_q[acc_idx]) min_y_q[acc_idx] <= s2_y_q;
         if (s2_y_q > max_y_q[acc_idx]) max_y_q[acc_idx] <= s2_y_q;
      end
   end

   //------------------------------------------------------------------
   // Outputs
   //------------------------------------------------------------------
   assign busy          = (state_q == StScan) || (state_q == StDrain);
   assign done          = (state_q == StDone);
   assign bin_addr_read = (state_q == StIdle) ? 19'd0 : addr_q;

   assign rd_idx = stat_bin - 3'd1;

   // Bin 0 reads all zeros, min fields included.
   always_comb begin
      stat_count = '0;
      stat_sum_x = '0;
      stat_sum_y = '0;
      stat_min_x = '0;
      stat_max_x = '0;
      stat_min_y = '0;
      stat_max_y = '0;
      if (stat_bin != 3'd0) begin
         stat_count = cnt_q[rd_idx];
         stat_sum_x = sum_x_q[rd_idx];
         stat_sum_y = sum_y_q[rd_idx];
         stat_min_x = min_x_q[rd_idx];
         stat_max_x = max_x_q[rd_idx];
         stat_min_y = min_y_q[rd_idx];
         stat_max_y = max_y_q[rd_idx];
      end
   end

endmodule
